// File: rtl/tv80_s.sv
// rtl/tv80_s.sv - Z80-compatible CPU core, reduced instruction subset
// Top level wraps the core; the register file is a separate module.

module tv80_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        we,
   input  logic        whi,
   input  logic [2:0]  waddr,
   input  logic [7:0]  wdata,
   input  logic [2:0]  raddr,
   input  logic        rhi,
   output logic [7:0]  rdata,
   input  logic [2:0]  hl_addr,
   output logic [15:0] hl
);

   logic [7:0] RegsH [0:7];
   logic [7:0] RegsL [0:7];

   // Single write port; the high/low half is selected by whi
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            RegsH[i] <= 8'h00;
            RegsL[i] <= 8'h00;
         end
      end else if (cen && we) begin
         if (whi)
            RegsH[waddr] <= wdata;
         else
            RegsL[waddr] <= wdata;
      end
   end

   assign rdata = rhi ? RegsH[raddr] : RegsL[raddr];
   assign hl    = {RegsH[hl_addr], RegsL[hl_addr]};

endmodule

module tv80_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        wait_n,
   input  logic        int_n,
   input  logic        nmi_n,
   input  logic        busrq_n,
   input  logic [7:0]  di,
   output logic        m1_n,
   output logic        mreq_n,
   output logic        rd_n,
   output logic        wr_n,
   output logic        rfsh_n,
   output logic        halt_n,
   output logic [15:0] A,
   output logic [7:0]  dout
);

   typedef enum logic [3:0] {
      S_RST, S_F1, S_F2, S_F3, S_F4, S_R1, S_R2, S_R3, S_W1, S_W2, S_W3
   } state_t;

   state_t state, state_nxt;

   logic [15:0] PC, SP, maddr;
   logic [7:0]  ACC, F, Ap, Fp, I, R, IR;
   logic        IntE_FF1, IntE_FF2, Halt_FF, Alternate;

   logic [2:0]  dst, src;
   logic        is_ldrr, is_ldrn, rd_hl, wr_hl, reg_op;
   logic [7:0]  rf_rdata, src_val;
   logic [15:0] hl;
   logic        rf_we;
   logic [7:0]  rf_wdata;

   // Interrupts, bus requests and the stack pointer are not exercised by this subset
   logic unused_ok;
   assign unused_ok = &{1'b0, int_n, nmi_n, busrq_n, SP};

   assign dst     = IR[5:3];
   assign src     = IR[2:0];
   assign is_ldrr = (IR[7:6] == 2'b01) && (IR != 8'h76);
   assign is_ldrn = (IR[7:6] == 2'b00) && (src == 3'd6) && (dst != 3'd6);
   assign rd_hl   = is_ldrr && (src == 3'd6);
   assign wr_hl   = is_ldrr && (dst == 3'd6);
   assign reg_op  = is_ldrr && (src != 3'd6) && (dst != 3'd6);
   assign src_val = (src == 3'd7) ? ACC : rf_rdata;

   // Register file writes: LD r,r' at end of T4, memory loads when the read data is sampled
   assign rf_we    = ((state == S_F4) && reg_op && (dst != 3'd7)) ||
                     ((state == S_R2) && wait_n && (rd_hl || is_ldrn) && (dst != 3'd7));
   assign rf_wdata = (state == S_R2) ? di : src_val;
   assign halt_n   = ~Halt_FF;

   tv80_reg regs (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .we      (rf_we),
      .whi     (~dst[0]),
      .waddr   ({Alternate, dst[2:1]}),
      .wdata   (rf_wdata),
      .raddr   ({Alternate, src[2:1]}),
      .rhi     (~src[0]),
      .rdata   (rf_rdata),
      .hl_addr ({Alternate, 2'b10}),
      .hl      (hl)
   );

   // T-state register; cen low freezes the sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_RST;
      else if (cen)
         state <= state_nxt;
   end

   // T-state sequencing; wait_n stretches T2 of every memory access
   always_comb begin
      state_nxt = state;
      case (state)
         S_RST: state_nxt = S_F1;
         S_F1:  state_nxt = S_F2;
         S_F2:  state_nxt = wait_n ? S_F3 : S_F2;
         S_F3:  state_nxt = S_F4;
         S_F4: begin
            if (rd_hl || is_ldrn)
               state_nxt = S_R1;
            else if (wr_hl)
               state_nxt = S_W1;
            else
               state_nxt = S_F1;
         end
         S_R1:  state_nxt = S_R2;
         S_R2:  state_nxt = wait_n ? S_R3 : S_R2;
         S_R3:  state_nxt = S_F1;
         S_W1:  state_nxt = S_W2;
         S_W2:  state_nxt = wait_n ? S_W3 : S_W2;
         S_W3:  state_nxt = S_F1;
         default: state_nxt = S_RST;
      endcase
   end

   // Bus strobes and address decoded from the current T-state
   always_comb begin
      m1_n   = 1'b1;
      mreq_n = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      rfsh_n = 1'b1;
      A      = 16'h0000;
      case (state)
         S_F1, S_F2: begin
            A = PC; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
         end
         S_F3, S_F4: begin
            A = {I, R}; mreq_n = 1'b0; rfsh_n = 1'b0;
         end
         S_R1, S_R2: begin
            A = maddr; mreq_n = 1'b0; rd_n = 1'b0;
         end
         S_W1: begin
            A = maddr; mreq_n = 1'b0;
         end
         S_W2: begin
            A = maddr; mreq_n = 1'b0; wr_n = 1'b0;
         end
         S_R3, S_W3: A = maddr;
         default: A = 16'h0000;
      endcase
   end

   // Architectural state: fetch latch, execute at end of T4, memory data at end of T2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PC        <= 16'h0000;
         SP        <= 16'hFFFF;
         ACC       <= 8'hFF;
         F         <= 8'hFF;
         Ap        <= 8'hFF;
         Fp        <= 8'hFF;
         I         <= 8'h00;
         R         <= 8'h00;
         IR        <= 8'h00;
         IntE_FF1  <= 1'b0;
         IntE_FF2  <= 1'b0;
         Halt_FF   <= 1'b0;
         Alternate <= 1'b0;
         maddr     <= 16'h0000;
         dout      <= 8'h00;
      end else if (cen) begin
         case (state)
            S_F2: begin
               if (wait_n) begin
                  // While halted the fetch is repeated at the same PC and ignored
                  if (Halt_FF) begin
                     IR <= 8'h00;
                  end else begin
                     IR <= di;
                     PC <= PC + 16'd1;
                  end
               end
            end
            S_F4: begin
               R     <= {R[7], R[6:0] + 7'd1};
               maddr <= is_ldrn ? PC : hl;
               if (wr_hl)
                  dout <= src_val;
               case (IR)
                  8'h76: Halt_FF <= 1'b1;
                  8'h08: begin
                     ACC <= Ap;
                     Ap  <= ACC;
                     F   <= Fp;
                     Fp  <= F;
                  end
                  8'hD9: Alternate <= ~Alternate;
                  8'hF3: begin
                     IntE_FF1 <= 1'b0;
                     IntE_FF2 <= 1'b0;
                  end
                  8'hFB: begin
                     IntE_FF1 <= 1'b1;
                     IntE_FF2 <= 1'b1;
                  end
                  default: begin
                     if (reg_op && (dst == 3'd7))
                        ACC <= src_val;
                  end
               endcase
            end
            S_R2: begin
               if (wait_n) begin
                  if (is_ldrn)
                     PC <= PC + 16'd1;
                  if (dst == 3'd7)
                     ACC <= di;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

module tv80_s (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cen,
   input  logic        wait_n,
   input  logic        int_n,
   input  logic        nmi_n,
   input  logic        busrq_n,
   output logic        m1_n,
   output logic        mreq_n,
   output logic        iorq_n,
   output logic        rd_n,
   output logic        wr_n,
   output logic        rfsh_n,
   output logic        halt_n,
   output logic        busak_n,
   output logic [15:0] A,
   input  logic [7:0]  di,
   output logic [7:0]  dout
);

   assign iorq_n  = 1'b1;
   assign busak_n = 1'b1;

   tv80_core core (
      .clk     (clk),
      .rst_n   (reset_n),
      .cen     (cen),
      .wait_n  (wait_n),
      .int_n   (int_n),
      .nmi_n   (nmi_n),
      .busrq_n (busrq_n),
      .di      (di),
      .m1_n    (m1_n),
      .mreq_n  (mreq_n),
      .rd_n    (rd_n),
      .wr_n    (wr_n),
      .rfsh_n  (rfsh_n),
      .halt_n  (halt_n),
      .A       (A),
      .dout    (dout)
   );

endmodule

// File: tb/tb_tv80_s.sv
// tb/tb_tv80_s.sv - Self-checking bench for tv80_s against an instruction-level model

module tb_tv80_s;

   logic        clk;
   logic        reset_n, cen, wait_n, int_n, nmi_n, busrq_n;
   logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n;
   logic [15:0] A;
   logic [7:0]  di, dout;

   logic [7:0]  mem  [0:65535];
   logic [7:0]  mmem [0:65535];

   int checks;
   int failures;
   int wr_pulses = 0;

   logic [15:0] m_pc;
   logic [7:0]  m_a, m_f, m_ap, m_fp, m_r;
   logic        m_alt, m_iff, m_halt;
   logic [7:0]  bank [0:1][0:5];

   tv80_s dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cen     (cen),
      .wait_n  (wait_n),
      .int_n   (int_n),
      .nmi_n   (nmi_n),
      .busrq_n (busrq_n),
      .m1_n    (m1_n),
      .mreq_n  (mreq_n),
      .iorq_n  (iorq_n),
      .rd_n    (rd_n),
      .wr_n    (wr_n),
      .rfsh_n  (rfsh_n),
      .halt_n  (halt_n),
      .busak_n (busak_n),
      .A       (A),
      .di      (di),
      .dout    (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign di = mem[A];

   always @(negedge wr_n) wr_pulses++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] getr(input logic [2:0] c);
      if (c == 3'd7) return m_a;
      return bank[m_alt][c];
   endfunction

   task automatic setr(input logic [2:0] c, input logic [7:0] v);
      if (c == 3'd7) m_a = v;
      else bank[m_alt][c] = v;
   endtask

   function automatic logic [15:0] m_hl();
      return {bank[m_alt][4], bank[m_alt][5]};
   endfunction

   // Bank b, register code c (B,C,D,E,H,L) as held in the DUT register file
   function automatic logic [7:0] dut_reg(input int b, input int c);
      logic [2:0] idx;
      idx = 3'(b * 4 + c / 2);
      return (c % 2 == 0) ? dut.core.regs.RegsH[idx] : dut.core.regs.RegsL[idx];
   endfunction

   function automatic logic [7:0] gen_byte();
      logic [7:0] b;
      case ($urandom_range(0, 5))
         0, 1: b = 8'($urandom);
         2: b = 8'h40 | 8'($urandom_range(0, 63));
         3: b = 8'h06 | 8'($urandom_range(0, 7) << 3);
         4: begin
            case ($urandom_range(0, 4))
               0: b = 8'h00;
               1: b = 8'h08;
               2: b = 8'hD9;
               3: b = 8'hF3;
               default: b = 8'hFB;
            endcase
         end
         default: b = $urandom_range(0, 1) ? (8'h46 | 8'($urandom_range(0, 7) << 3))
                                           : (8'h70 | 8'($urandom_range(0, 7)));
      endcase
      if (b == 8'h76) b = 8'h00;
      return b;
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_a = 8'hFF; m_f = 8'hFF; m_ap = 8'hFF; m_fp = 8'hFF;
      m_r = 8'h00; m_alt = 1'b0; m_iff = 1'b0; m_halt = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int c = 0; c < 6; c++)
            bank[b][c] = 8'h00;
   endtask

   task automatic check_state();
      chk("pc", dut.core.PC, m_pc);
      chk("acc", {8'h00, dut.core.ACC}, {8'h00, m_a});
      chk("f", {8'h00, dut.core.F}, {8'h00, m_f});
      chk("ap", {8'h00, dut.core.Ap}, {8'h00, m_ap});
      chk("fp", {8'h00, dut.core.Fp}, {8'h00, m_fp});
      chk("r", {8'h00, dut.core.R}, {8'h00, m_r});
      chk("i", {8'h00, dut.core.I}, 16'h0000);
      chk("sp", dut.core.SP, 16'hFFFF);
      chk("alt", {15'h0, dut.core.Alternate}, {15'h0, m_alt});
      chk("iff1", {15'h0, dut.core.IntE_FF1}, {15'h0, m_iff});
      chk("iff2", {15'h0, dut.core.IntE_FF2}, {15'h0, m_iff});
      chk("halt_ff", {15'h0, dut.core.Halt_FF}, {15'h0, m_halt});
      chk("halt_n", {15'h0, halt_n}, {15'h0, !m_halt});
      for (int b = 0; b < 2; b++)
         for (int c = 0; c < 6; c++)
            chk($sformatf("reg%0d_%0d", b, c), {8'h00, dut_reg(b, c)}, {8'h00, bank[b][c]});
   endtask

   // One instruction: bus checks at each M-cycle, model update, full state compare
   task automatic step(input bit rnd);
      logic [15:0] pc0, pcf, addr;
      logic [7:0]  r0, op, wv, t;
      logic [2:0]  d, s;
      int          kind, k;
      pc0 = m_pc; r0 = m_r; kind = 0; addr = 16'h0000; wv = 8'h00;
      chk("m1_addr", A, pc0);
      chk("m1_n", {15'h0, m1_n}, 16'h0000);
      chk("m1_mreq", {15'h0, mreq_n}, 16'h0000);
      chk("m1_rd", {15'h0, rd_n}, 16'h0000);
      if (m_halt) op = 8'h00;
      else begin
         op = mmem[pc0];
         m_pc = pc0 + 16'd1;
      end
      pcf = m_pc;
      m_r = (r0 & 8'h80) | ((r0 + 8'd1) & 8'h7F);
      d = op[5:3];
      s = op[2:0];
      if (op == 8'h76) m_halt = 1'b1;
      else if (op == 8'h08) begin
         t = m_a; m_a = m_ap; m_ap = t;
         t = m_f; m_f = m_fp; m_fp = t;
      end
      else if (op == 8'hD9) m_alt = ~m_alt;
      else if (op == 8'hF3) m_iff = 1'b0;
      else if (op == 8'hFB) m_iff = 1'b1;
      else if (op >= 8'h40 && op <= 8'h7F) begin
         if (s == 3'd6) begin kind = 1; addr = m_hl(); end
         else if (d == 3'd6) begin kind = 2; addr = m_hl(); wv = getr(s); end
         else setr(d, getr(s));
      end
      else if (op < 8'h40 && s == 3'd6 && d != 3'd6) begin
         kind = 1; addr = m_pc;
      end
      tick(2);
      chk("rfsh_addr", A, {8'h00, r0});
      chk("rfsh_n", {15'h0, rfsh_n}, 16'h0000);
      chk("m1_n_t3", {15'h0, m1_n}, 16'h0001);
      if (rnd && $urandom_range(0, 3) == 0) begin
         cen = 1'b0;
         tick($urandom_range(1, 4));
         chk("hold_addr", A, {8'h00, r0});
         chk("hold_rfsh", {15'h0, rfsh_n}, 16'h0000);
         chk("hold_pc", dut.core.PC, pcf);
         chk("hold_r", {8'h00, dut.core.R}, {8'h00, r0});
         cen = 1'b1;
      end
      tick(2);
      if (kind == 1) begin
         chk("rd_addr", A, addr);
         chk("rd_n", {15'h0, rd_n}, 16'h0000);
         chk("rd_mreq", {15'h0, mreq_n}, 16'h0000);
         k = rnd ? $urandom_range(0, 3) : 0;
         if (k > 0) wait_n = 1'b0;
         tick(1);
         chk("rd_t2", {15'h0, rd_n}, 16'h0000);
         if (k > 0) begin
            tick(k);
            chk("rd_wait", {15'h0, rd_n}, 16'h0000);
            wait_n = 1'b1;
         end
         tick(2);
         setr(d, mmem[addr]);
         if (op < 8'h40) m_pc = m_pc + 16'd1;
      end else if (kind == 2) begin
         chk("wr_addr", A, addr);
         chk("wr_dout", {8'h00, dout}, {8'h00, wv});
         chk("wr_t1", {15'h0, wr_n}, 16'h0001);
         k = rnd ? $urandom_range(0, 3) : 0;
         if (k > 0) wait_n = 1'b0;
         tick(1);
         chk("wr_n", {15'h0, wr_n}, 16'h0000);
         mem[A] = dout;
         if (k > 0) begin
            tick(k);
            wait_n = 1'b1;
         end
         tick(2);
         mmem[addr] = wv;
         chk("mem_wr", {8'h00, mem[addr]}, {8'h00, mmem[addr]});
      end
      check_state();
   endtask

   task automatic put(input int a, input logic [7:0] v);
      mem[a] = v;
      mmem[a] = v;
   endtask

   initial begin
      logic [15:0] pc_h;
      int          w0, a;
      logic [7:0]  prog [0:29];
      checks = 0; failures = 0;
      reset_n = 1'b0; cen = 1'b1; wait_n = 1'b1;
      int_n = 1'b1; nmi_n = 1'b1; busrq_n = 1'b1;

      for (int i = 0; i < 65536; i++) put(i, 8'($urandom));
      prog = '{8'h3E, 8'h02, 8'h06, 8'hCF, 8'h0E, 8'h98, 8'h16, 8'h90, 8'h1E, 8'hD8,
               8'h26, 8'hA1, 8'h2E, 8'h69, 8'h7B, 8'h46, 8'h3E, 8'h3C, 8'h26, 8'h12,
               8'h2E, 8'h34, 8'h77, 8'h3E, 8'h9A, 8'h08, 8'hD9, 8'h08, 8'hD9, 8'hFB};
      for (int i = 0; i < 30; i++) put(i, prog[i]);
      for (int i = 30; i < 1024; i++) put(i, gen_byte());
      put(16'hA169, 8'h50);
      model_reset();

      tick(3);
      chk("rst_pc", dut.core.PC, 16'h0000);
      chk("rst_sp", dut.core.SP, 16'hFFFF);
      chk("rst_acc", {8'h00, dut.core.ACC}, 16'h00FF);
      chk("rst_f", {8'h00, dut.core.F}, 16'h00FF);
      chk("rst_i", {8'h00, dut.core.I}, 16'h0000);
      chk("rst_r", {8'h00, dut.core.R}, 16'h0000);
      chk("rst_iff", {14'h0, dut.core.IntE_FF1, dut.core.IntE_FF2}, 16'h0000);
      chk("rst_halt", {14'h0, dut.core.Halt_FF, dut.core.Alternate}, 16'h0000);
      chk("rst_strobes", {8'h00, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n}, 16'h00FF);
      chk("rst_a", A, 16'h0000);
      chk("rst_dout", {8'h00, dout}, 16'h0000);

      reset_n = 1'b1;
      tick(1);

      repeat (7) step(1'b0);
      step(1'b0);
      chk("ld_a_e", {8'h00, dut.core.ACC}, 16'h00D8);
      chk("bc", {dut_reg(0, 0), dut_reg(0, 1)}, 16'hCF98);
      chk("de", {dut_reg(0, 2), dut_reg(0, 3)}, 16'h90D8);
      chk("hl", {dut_reg(0, 4), dut_reg(0, 5)}, 16'hA169);
      chk("pc_ld_a_e", dut.core.PC, 16'h000F);
      chk("r_ld_a_e", {8'h00, dut.core.R}, 16'h0008);
      step(1'b0);
      chk("ld_b_hl", {8'h00, dut_reg(0, 0)}, 16'h0050);
      chk("pc_ld_b_hl", dut.core.PC, 16'h0010);
      repeat (3) step(1'b0);
      w0 = wr_pulses;
      step(1'b0);
      chk("ld_hl_a", {8'h00, mem[16'h1234]}, 16'h003C);
      chk("wr_pulses", 16'(wr_pulses - w0), 16'h0001);
      step(1'b0);
      chk("ld_a_n", {8'h00, dut.core.ACC}, 16'h009A);
      chk("pc_ld_a_n", dut.core.PC, 16'h0019);
      step(1'b0);
      chk("ex_acc", {8'h00, dut.core.ACC}, 16'h00FF);
      chk("ex_ap", {8'h00, dut.core.Ap}, 16'h009A);
      step(1'b0);
      chk("exx_alt", {15'h0, dut.core.Alternate}, 16'h0001);
      step(1'b0);
      step(1'b0);
      chk("exx_back", {15'h0, dut.core.Alternate}, 16'h0000);
      step(1'b0);
      chk("ei", {14'h0, dut.core.IntE_FF1, dut.core.IntE_FF2}, 16'h0003);

      repeat (300) step(1'b1);

      a = int'(m_pc);
      put(a, 8'h76);
      step(1'b1);
      chk("halt_n_low", {15'h0, halt_n}, 16'h0000);
      pc_h = dut.core.PC;
      repeat (3) step(1'b1);
      chk("halt_pc", dut.core.PC, pc_h);

      put(0, 8'h46);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      tick(6);
      chk("r3_rd_n", {15'h0, rd_n}, 16'h0001);
      chk("r3_pc", dut.core.PC, 16'h0001);
      reset_n = 1'b0;
      #1;
      chk("midrst_strobes", {8'h00, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n}, 16'h00FF);
      chk("midrst_pc", dut.core.PC, 16'h0000);
      chk("midrst_a", A, 16'h0000);
      tick(1);
      reset_n = 1'b1;
      tick(2);
      chk("f2_m1", {15'h0, m1_n}, 16'h0000);
      cen = 1'b0;
      tick(5);
      chk("cen_a", A, 16'h0000);
      chk("cen_strobes", {13'h0, m1_n, rd_n, rfsh_n}, 16'h0001);
      chk("cen_pc", dut.core.PC, 16'h0000);
      cen = 1'b1;
      tick(1);
      chk("cen_resume_pc", dut.core.PC, 16'h0001);
      chk("cen_resume_rfsh", {15'h0, rfsh_n}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
